// File: rtl/fifo_pkg.sv
// Shared FIFO constants used by the controller and the storage array.
// Also holds the operation decode helper used by the occupancy counter.
package fifo_pkg;

  localparam int PTR_W     = 3;
  localparam int DEPTH     = 8;
  localparam int DATA_W    = 12;
  localparam int AF_THRESH = 6;
  localparam int AE_THRESH = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic wr, input logic rd);
    fifo_op_e op;
    case ({wr, rd})
      2'b10:   op = OP_WR;
      2'b01:   op = OP_RD;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Handshake, pointer and status bundle between a FIFO user and fifo_ctrl.
// The master drives push/pop; the controller (slave) drives everything else.
interface fifo_ctrl_if #(
  parameter int PTR_W = fifo_pkg::PTR_W
);

  logic             push;
  logic             pop;
  logic             write;
  logic             read;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop,
    input  write, read, wr_ptr, rd_ptr, count,
    input  full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  push, pop,
    output write, read, wr_ptr, rd_ptr, count,
    output full, empty, almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping PTR_W-bit address counter with synchronous reset and increment enable.
module fifo_ptr #(
  parameter int PTR_W = fifo_pkg::PTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_r;

  // Pointer register; the natural PTR_W-bit rollover gives the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (inc) begin
      ptr_r <= ptr_r + PTR_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: accepts push/pop, tracks occupancy and drives memory strobes.
// Define FIFO_CTRL_ERR_EN to implement the sticky overflow/underflow registers.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = fifo_pkg::DEPTH,
  parameter int PTR_W     = fifo_pkg::PTR_W,
  parameter int AF_THRESH = fifo_pkg::AF_THRESH,
  parameter int AE_THRESH = fifo_pkg::AE_THRESH
) (
  input logic       clk,
  input logic       reset,
  fifo_ctrl_if.slave bus
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] AF_C    = (PTR_W+1)'(AF_THRESH);
  localparam logic [PTR_W:0] AE_C    = (PTR_W+1)'(AE_THRESH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

  logic [PTR_W:0]   count_r;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [PTR_W-1:0] rd_ptr_s;
  logic             write_s;
  logic             read_s;
  logic             full_s;
  logic             empty_s;
  logic             af_s;
  logic             ae_s;
  logic             overflow_s;
  logic             underflow_s;
  fifo_op_e         op_s;

  // Status decode from the registered count; reset forces the empty-side view.
  always_comb begin
    full_s  = 1'b0;
    empty_s = 1'b1;
    af_s    = 1'b0;
    ae_s    = 1'b1;
    if (reset) begin
      full_s  = 1'b0;
      empty_s = 1'b1;
      af_s    = 1'b0;
      ae_s    = 1'b1;
    end else begin
      full_s  = (count_r == DEPTH_C);
      empty_s = (count_r == '0);
      af_s    = (count_r >= AF_C);
      ae_s    = (count_r <= AE_C);
    end
  end

  // Accepted strobes are combinational so the memory sees them in the same cycle.
  always_comb begin
    write_s = 1'b0;
    read_s  = 1'b0;
    if (reset) begin
      write_s = 1'b0;
      read_s  = 1'b0;
    end else begin
      write_s = bus.push & ~full_s;
      read_s  = bus.pop & ~empty_s;
    end
  end

  assign op_s = decode_op(write_s, read_s);

  // Occupancy counter; gated strobes keep it within 0..DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else begin
      case (op_s)
        OP_WR:   count_r <= count_r + ONE_C;
        OP_RD:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (write_s),
    .ptr   (wr_ptr_s)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (read_s),
    .ptr   (rd_ptr_s)
  );

`ifdef FIFO_CTRL_ERR_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags: rejected push when full, rejected pop when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r | (bus.push & full_s);
      underflow_r <= underflow_r | (bus.pop & empty_s);
    end
  end

  assign overflow_s  = overflow_r;
  assign underflow_s = underflow_r;
`else
  assign overflow_s  = 1'b0;
  assign underflow_s = 1'b0;
`endif

  assign bus.write        = write_s;
  assign bus.read         = read_s;
  assign bus.wr_ptr       = wr_ptr_s;
  assign bus.rd_ptr       = rd_ptr_s;
  assign bus.count        = count_r;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = af_s;
  assign bus.almost_empty = ae_s;
  assign bus.overflow     = overflow_s;
  assign bus.underflow    = underflow_s;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: a queue-based occupancy model predicts every
// cycle's outputs; a negedge monitor pops and compares them against the DUT.
module tb_fifo_ctrl;

  localparam int DEPTH = fifo_pkg::DEPTH;
  localparam int AF    = fifo_pkg::AF_THRESH;
  localparam int AE    = fifo_pkg::AE_THRESH;

  typedef struct packed {
    logic       write;
    logic       read;
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  fifo_ctrl_if bus ();

  fifo_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   model_q[$];
  int   wr_tot, rd_tot, seq;
  bit   ovf_m, unf_m;
  int   n_cmp, n_err;

  // One stimulus cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input bit p, input bit q, input bit r);
    exp_t e;
    int   sz;
    @(posedge clk);
    #1;
    bus.push = p;
    bus.pop  = q;
    reset    = r;
    sz       = model_q.size();
    e.write  = !r && p && (sz < DEPTH);
    e.read   = !r && q && (sz > 0);
    e.wr_ptr = 3'(wr_tot % DEPTH);
    e.rd_ptr = 3'(rd_tot % DEPTH);
    e.count  = 4'(sz);
    e.full   = !r && (sz == DEPTH);
    e.empty  = r || (sz == 0);
    e.af     = !r && (sz >= AF);
    e.ae     = r || (sz <= AE);
    e.ovf    = ovf_m;
    e.unf    = unf_m;
    exp_q.push_back(e);
    if (r) begin
      model_q.delete();
      wr_tot = 0;
      rd_tot = 0;
      ovf_m  = 1'b0;
      unf_m  = 1'b0;
    end else begin
      if (e.read) begin
        void'(model_q.pop_front());
        rd_tot++;
      end
      if (e.write) begin
        model_q.push_back(seq);
        seq++;
        wr_tot++;
      end
`ifdef FIFO_CTRL_ERR_EN
      if (p && sz == DEPTH) ovf_m = 1'b1;
      if (q && sz == 0) unf_m = 1'b1;
`endif
    end
  endtask

  // Monitor: compare every presented cycle against the oldest prediction.
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g.write  = bus.write;
        g.read   = bus.read;
        g.wr_ptr = bus.wr_ptr;
        g.rd_ptr = bus.rd_ptr;
        g.count  = bus.count;
        g.full   = bus.full;
        g.empty  = bus.empty;
        g.af     = bus.almost_full;
        g.ae     = bus.almost_empty;
        g.ovf    = bus.overflow;
        g.unf    = bus.underflow;
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL cycle_outputs t=%0t got wr=%b rd=%b wp=%0d rp=%0d cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b want wr=%b rd=%b wp=%0d rp=%0d cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b",
                   $time, g.write, g.read, g.wr_ptr, g.rd_ptr, g.count, g.full, g.empty, g.af, g.ae, g.ovf, g.unf,
                   e.write, e.read, e.wr_ptr, e.rd_ptr, e.count, e.full, e.empty, e.af, e.ae, e.ovf, e.unf);
        end
      end
    end
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    wr_tot   = 0;
    rd_tot   = 0;
    seq      = 0;
    ovf_m    = 1'b0;
    unf_m    = 1'b0;
    reset    = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held with both requests active.
    repeat (2) step(1'b1, 1'b1, 1'b1);
    // Fill past full, then drain past empty.
    repeat (9) step(1'b1, 1'b0, 1'b0);
    repeat (9) step(1'b0, 1'b1, 1'b0);
    // Simultaneous push/pop at count 4.
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // Simultaneous push/pop when empty.
    repeat (4) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    // Simultaneous push/pop when full.
    repeat (8) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // Reset mid-stream at count 5 with push active.
    repeat (2) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Random traffic with biased phases so both full and empty are reached.
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = ((i / 50) % 2 == 0) ? 75 : 25;
      step(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) >= bias),
           ($urandom_range(0, 99) < 2));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
